run_monitor: RTL

Synthesizable run-control and register-dump monitor for the single-cycle CPU top, replacing testbench-only halt and dump logic.
- Watches the retired PC stream.
- Stops the CPU on any of NUM_BP breakpoints, a programmable cycle timeout, or a PC-error flag.
- Walks the register file through the CPU's reg_sel/reg_data debug port and streams the contents out over a valid/ready interface.

---
 rtl/run_mon_pkg.sv | 17 +
 rtl/run_monitor_bp_match.sv | 26 ++
 rtl/run_monitor.sv | 112 +++++++++++
 3 files changed

// File: rtl/run_mon_pkg.sv
// run_mon_pkg: shared state encoding, stop-cause codes and width helpers for run_monitor
package run_mon_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STOP, S_LOAD, S_WAIT, S_DONE} state_t;
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_BP      = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_PCERR   = 2'd3;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int hit_w(input int n);
    return clog2(n) > 0 ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/run_monitor_bp_match.sv
// bp_match: parallel PC breakpoint comparators with lowest-index priority
module bp_match
  import run_mon_pkg::*;
#(
  parameter int NUM_BP = 2,
  parameter int PC_W   = 32
) (
  input  logic [PC_W-1:0]        pc,
  input  logic                   pc_valid,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   hit,
  output logic [hit_w(NUM_BP)-1:0] hit_idx
);
  localparam int HW = hit_w(NUM_BP);
  // scanning downward lets the lowest matching index overwrite higher ones
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (pc_valid && bp_en[i] && pc == bp_addr[i*PC_W +: PC_W]) begin
        hit = 1'b1;
        hit_idx = HW'(i);
      end
  end
endmodule

// File: rtl/run_monitor.sv
// run_monitor: halts the CPU on breakpoint/timeout/pc error, then streams the register file out
module run_monitor
  import run_mon_pkg::*;
#(
  parameter int NUM_BP = 2,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_W-1:0]        pc,
  input  logic                   pc_valid,
  input  logic                   pc_err,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [CNT_W-1:0]       timeout_limit,
  output logic                   cpu_halt,
  output logic [SEL_W-1:0]       reg_sel,
  input  logic [DATA_W-1:0]      reg_data,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [SEL_W-1:0]       dump_idx,
  output logic [DATA_W-1:0]      dump_data,
  output logic                   dump_last,
  output logic                   done,
  output logic [1:0]             cause,
  output logic [hit_w(NUM_BP)-1:0] hit_idx,
  output logic [CNT_W-1:0]       cycle_count
);
  localparam int HW = hit_w(NUM_BP);
  state_t state, nxt;
  logic [SEL_W-1:0] idx;
  logic [CNT_W-1:0] cnt_inc;
  logic [HW-1:0] bp_idx;
  logic bp_hit, err_stop, to_stop, stop, accept;
  bp_match #(.NUM_BP(NUM_BP), .PC_W(PC_W)) u_bp (
    .pc(pc), .pc_valid(pc_valid), .bp_addr(bp_addr), .bp_en(bp_en),
    .hit(bp_hit), .hit_idx(bp_idx)
  );
  // stop decisions use count+1 so the matching cycle is the last one counted
  always_comb begin
    cnt_inc = cycle_count + 1'b1;
    err_stop = pc_valid & pc_err;
    to_stop = |timeout_limit && cnt_inc == timeout_limit;
    stop = err_stop | bp_hit | to_stop;
    accept = dump_valid & dump_ready;
  end
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: nxt = start ? S_RUN : state;
      S_RUN:          nxt = stop ? S_STOP : S_RUN;
      S_STOP:         nxt = S_LOAD;
      S_LOAD:         nxt = S_WAIT;
      S_WAIT:         nxt = accept ? (dump_last ? S_DONE : S_LOAD) : S_WAIT;
      default:        nxt = S_IDLE;
    endcase
  end
  always_comb begin
    cpu_halt = state inside {S_STOP, S_LOAD, S_WAIT, S_DONE};
    done = state == S_DONE;
    reg_sel = idx;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cycle_count <= '0;
      cause <= CAUSE_NONE;
      hit_idx <= '0;
      idx <= '0;
      dump_valid <= 1'b0;
      dump_idx <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            cycle_count <= '0;
            cause <= CAUSE_NONE;
            hit_idx <= '0;
            idx <= '0;
          end
        S_RUN: begin
          cycle_count <= &cycle_count ? cycle_count : cnt_inc;
          if (stop) begin
            cause <= err_stop ? CAUSE_PCERR : bp_hit ? CAUSE_BP : CAUSE_TIMEOUT;
            hit_idx <= (!err_stop && bp_hit) ? bp_idx : '0;
          end
        end
        S_STOP: idx <= '0;
        S_LOAD: begin
          dump_data <= idx == '0 ? '0 : reg_data;
          dump_idx <= idx;
          dump_last <= idx == SEL_W'(NREG - 1);
          dump_valid <= 1'b1;
        end
        S_WAIT:
          if (accept) begin
            dump_valid <= 1'b0;
            if (!dump_last) idx <= idx + 1'b1;
          end
        default: ;
      endcase
    end
endmodule
